// File: rtl/imm_extend_unit.sv
// ============================================================================
// Module   : imm_extend_unit
// Function : Pipelined immediate extension (SEXT/ZEXT/LUI/BR) with a
//            two-entry skid buffer on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_unit #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int         c_PAD       = OUT_W - IN_W;
  localparam logic [1:0] c_MODE_SEXT = 2'd0;
  localparam logic [1:0] c_MODE_ZEXT = 2'd1;
  localparam logic [1:0] c_MODE_LUI  = 2'd2;
  localparam logic [1:0] c_MODE_BR   = 2'd3;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_lui;
  logic [OUT_W-1:0] w_br;
  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_drain;

  logic             r_o_valid;
  logic [OUT_W-1:0] r_o_imm;
  logic [TAG_W-1:0] r_o_tag;
  logic             r_s_valid;
  logic [OUT_W-1:0] r_s_imm;
  logic [TAG_W-1:0] r_s_tag;
  logic             r_in_ready;

  // Size casts of a signed operand sign-extend; OUT_W >= IN_W + BR_SHIFT keeps BR lossless.
  assign w_sext = OUT_W'($signed(in_imm));
  assign w_zext = OUT_W'(in_imm);
  assign w_lui  = w_zext << c_PAD;
  assign w_br   = w_sext << BR_SHIFT;

  always_comb begin
    w_ext = w_sext;
    case (in_mode)
      c_MODE_SEXT: w_ext = w_sext;
      c_MODE_ZEXT: w_ext = w_zext;
      c_MODE_LUI:  w_ext = w_lui;
      c_MODE_BR:   w_ext = w_br;
      default:     w_ext = w_sext;
    endcase
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_o_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid  <= 1'b0;
      r_o_imm    <= '0;
      r_o_tag    <= '0;
      r_s_valid  <= 1'b0;
      r_s_imm    <= '0;
      r_s_tag    <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_o_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_drain && r_s_valid) begin
        // Skid entry advances; a same-cycle accept refills the skid slot.
        r_o_imm    <= r_s_imm;
        r_o_tag    <= r_s_tag;
        r_o_valid  <= 1'b1;
        if (w_accept) begin
          r_s_imm    <= w_ext;
          r_s_tag    <= in_tag;
          r_s_valid  <= 1'b1;
          r_in_ready <= 1'b0;
        end else begin
          r_s_valid  <= 1'b0;
          r_in_ready <= 1'b1;
        end
      end else if (w_accept && (!r_o_valid || w_drain)) begin
        r_o_imm    <= w_ext;
        r_o_tag    <= in_tag;
        r_o_valid  <= 1'b1;
        r_in_ready <= !r_s_valid;
      end else if (w_accept) begin
        r_s_imm    <= w_ext;
        r_s_tag    <= in_tag;
        r_s_valid  <= 1'b1;
        r_in_ready <= 1'b0;
      end else if (w_drain) begin
        r_o_valid  <= 1'b0;
        r_in_ready <= !r_s_valid;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_o_valid;
  assign out_imm   = r_o_imm;
  assign out_tag   = r_o_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
// ============================================================================
// Module   : tb_imm_extend_unit
// Function : Self-checking bench for imm_extend_unit (default and 12-bit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [1:0]  p_in_mode;
  logic [4:0]  p_in_tag;
  logic        p_out_valid;
  logic [31:0] p_out_imm;
  logic [4:0]  p_out_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];
  vec_t pvecs[5];

  always #5 clk = ~clk;

  imm_extend_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(32), .BR_SHIFT(1), .TAG_W(5)) dut12 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm),
    .in_mode(p_in_mode), .in_tag(p_in_tag),
    .out_valid(p_out_valid), .out_ready(1'b1),
    .out_imm(p_out_imm), .out_tag(p_out_tag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag);
    in_valid = v;
    in_mode  = m;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h8001, 5'd1,  32'hFFFF8001};
    vecs[1] = '{2'd1, 16'h8001, 5'd2,  32'h00008001};
    vecs[2] = '{2'd2, 16'h1234, 5'd3,  32'h12340000};
    vecs[3] = '{2'd3, 16'hFFFF, 5'd4,  32'hFFFFFFFC};
    vecs[4] = '{2'd3, 16'h0004, 5'd5,  32'h00000010};
    vecs[5] = '{2'd0, 16'h7FFF, 5'd6,  32'h00007FFF};
    vecs[6] = '{2'd2, 16'hFFFF, 5'd7,  32'hFFFF0000};
    vecs[7] = '{2'd1, 16'hFFFF, 5'd31, 32'h0000FFFF};

    pvecs[0] = '{2'd0, 16'h0800, 5'd9,  32'hFFFFF800};
    pvecs[1] = '{2'd3, 16'h07FF, 5'd10, 32'h00000FFE};
    pvecs[2] = '{2'd2, 16'h0ABC, 5'd11, 32'hABC00000};
    pvecs[3] = '{2'd1, 16'h0800, 5'd12, 32'h00000800};
    pvecs[4] = '{2'd3, 16'h0800, 5'd13, 32'hFFFFF000};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    p_in_valid = 1'b0; p_in_imm = '0; p_in_mode = '0; p_in_tag = '0;
    step(); step();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_imm", out_imm, 32'd0);
    chk("reset out_tag", {27'b0, out_tag}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Mode sweep streamed back-to-back: each result checked one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm, vecs[i].tag);
      step();
      chk($sformatf("stream[%0d] out_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stream[%0d] out_imm", i), out_imm, vecs[i].exp);
      chk($sformatf("stream[%0d] out_tag", i), {27'b0, out_tag}, {27'b0, vecs[i].tag});
      chk($sformatf("stream[%0d] in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    step();
    chk("stream idle out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: A, B accepted; C held upstream until recovery.
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 16'h00AA, 5'd1);
    step();
    chk("bp A out_imm", out_imm, 32'h000000AA);
    chk("bp A in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 2'd1, 16'h00BB, 5'd2);
    step();
    chk("bp B in_ready low", {31'b0, in_ready}, 32'd0);
    chk("bp hold A", out_imm, 32'h000000AA);
    drive(1'b1, 2'd1, 16'h00CC, 5'd3);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("bp stall[%0d] out_imm", k), out_imm, 32'h000000AA);
      chk($sformatf("bp stall[%0d] out_tag", k), {27'b0, out_tag}, 32'd1);
      chk($sformatf("bp stall[%0d] in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp B out_imm", out_imm, 32'h000000BB);
    chk("bp B out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp recover in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("bp C out_imm", out_imm, 32'h000000CC);
    chk("bp C out_tag", {27'b0, out_tag}, 32'd3);
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    step();
    chk("bp drained out_valid", {31'b0, out_valid}, 32'd0);

    // Flush with O and S full while in_valid is high.
    out_ready = 1'b0;
    drive(1'b1, 2'd1, 16'h0011, 5'd4);
    step();
    drive(1'b1, 2'd1, 16'h0022, 5'd5);
    step();
    drive(1'b1, 2'd1, 16'h0033, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    chk("flush full out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush full in_ready", {31'b0, in_ready}, 32'd1);
    // Flush with only O full: in_ready high, so the flush-cycle input would otherwise be accepted.
    drive(1'b1, 2'd1, 16'h0044, 5'd7);
    step();
    drive(1'b1, 2'd1, 16'h0055, 5'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    out_ready = 1'b1;
    chk("flush O out_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("flush discarded input", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 2'd0, 16'h0066, 5'd9);
    step();
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    chk("post-flush out_imm", out_imm, 32'h00000066);
    chk("post-flush out_tag", {27'b0, out_tag}, 32'd9);
    step();

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 16'hF00F, 5'd10);
    step();
    drive(1'b1, 2'd0, 16'h0F0F, 5'd11);
    step();
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("async rst out_imm", out_imm, 32'd0);
    chk("async rst out_tag", {27'b0, out_tag}, 32'd0);
    chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post-rst idle", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 2'd3, 16'h8000, 5'd12);
    step();
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    chk("post-rst out_imm", out_imm, 32'hFFFE0000);
    chk("post-rst out_tag", {27'b0, out_tag}, 32'd12);
    step();
    chk("post-rst drained", {31'b0, out_valid}, 32'd0);

    // Parameter variant: IN_W=12, BR_SHIFT=1.
    for (int i = 0; i < 5; i++) begin
      p_in_valid = 1'b1;
      p_in_mode  = pvecs[i].mode;
      p_in_imm   = pvecs[i].imm[11:0];
      p_in_tag   = pvecs[i].tag;
      step();
      chk($sformatf("p12[%0d] out_valid", i), {31'b0, p_out_valid}, 32'd1);
      chk($sformatf("p12[%0d] out_imm", i), p_out_imm, pvecs[i].exp);
      chk($sformatf("p12[%0d] out_tag", i), {27'b0, p_out_tag}, {27'b0, pvecs[i].tag});
      chk($sformatf("p12[%0d] in_ready", i), {31'b0, p_in_ready}, 32'd1);
    end
    p_in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
